// File: rtl/rv_pl_run_ctrl.sv
// Run controller for rv_pl_wrapper: loads IMEM/DMEM while the core is held, then releases it and times the run.
// Optional build macro RV_RUN_TIMEOUT_EN adds a TIMEOUT state bounded by TIMEOUT_CYC run cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | core held, loader owns BRAM write ports, loads accepted
// S_HOLD    | start seen, core still held for RST_HOLD cycles
// S_RUN     | core released, cycle counter running, done_flag filtered
// S_DONE    | completion latched, core re-held, count frozen
// S_TIMEOUT | run limit hit without completion (RV_RUN_TIMEOUT_EN only)
module rv_pl_run_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int RST_HOLD    = 5,
  parameter int DONE_STABLE = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              start,
  input  logic              clear,
  input  logic              done_flag,
  output logic              core_rst_n,
  output logic              mem_owner,
  output logic              imem_we,
  output logic [3:0]        dmem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_count
);

`ifdef RV_RUN_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_DONE, S_TIMEOUT} state_t;
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC);
`else
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;
`endif

  localparam logic [7:0] HOLD_LOAD = 8'(RST_HOLD - 1);
  localparam logic [3:0] STAB_TC   = 4'(DONE_STABLE);

  state_t              state, state_nxt;
  logic [7:0]          hold_cnt, hold_nxt;
  logic [3:0]          stab_cnt, stab_nxt;
  logic [31:0]         cnt_nxt;
  logic                accept;
  logic                imem_we_nxt;
  logic [3:0]          dmem_we_nxt;
  logic [ADDR_W-1:0]   waddr_nxt;
  logic [31:0]         wdata_nxt;
  logic                core_rst_n_nxt, mem_owner_nxt, ld_ready_nxt;
  logic                busy_nxt, done_nxt, timeout_nxt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      stab_cnt    <= '0;
      cycle_count <= '0;
      imem_we     <= 1'b0;
      dmem_we     <= '0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      core_rst_n  <= 1'b0;
      mem_owner   <= 1'b1;
      ld_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      stab_cnt    <= stab_nxt;
      cycle_count <= cnt_nxt;
      imem_we     <= imem_we_nxt;
      dmem_we     <= dmem_we_nxt;
      mem_waddr   <= waddr_nxt;
      mem_wdata   <= wdata_nxt;
      core_rst_n  <= core_rst_n_nxt;
      mem_owner   <= mem_owner_nxt;
      ld_ready    <= ld_ready_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      timeout     <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    stab_nxt    = stab_cnt;
    cnt_nxt     = cycle_count;
    waddr_nxt   = mem_waddr;
    wdata_nxt   = mem_wdata;
    imem_we_nxt = 1'b0;
    dmem_we_nxt = '0;
    accept      = (state == S_IDLE) && ld_valid && ld_ready;

    // A load coinciding with start still lands; mem_owner is high for the first HOLD cycle.
    if (accept) begin
      waddr_nxt   = ld_addr;
      wdata_nxt   = ld_data;
      imem_we_nxt = ~ld_sel;
      dmem_we_nxt = {4{ld_sel}};
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_HOLD;
          hold_nxt  = HOLD_LOAD;
          cnt_nxt   = '0;
          stab_nxt  = '0;
        end
      end
      S_HOLD: begin
        if (hold_cnt == 8'd0) state_nxt = S_RUN;
        else                  hold_nxt  = hold_cnt - 8'd1;
      end
      S_RUN: begin
        if (cycle_count != 32'hFFFF_FFFF) cnt_nxt = cycle_count + 32'd1;
        if (!done_flag)              stab_nxt = '0;
        else if (stab_cnt != 4'hF)   stab_nxt = stab_cnt + 4'd1;
        if (done_flag && (stab_nxt >= STAB_TC)) state_nxt = S_DONE;
`ifdef RV_RUN_TIMEOUT_EN
        else if (cnt_nxt >= TO_LIM)             state_nxt = S_TIMEOUT;
`endif
      end
      S_DONE: begin
        if (clear) state_nxt = S_IDLE;
      end
`ifdef RV_RUN_TIMEOUT_EN
      S_TIMEOUT: begin
        if (clear) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase

    // Ownership is handed to the core one cycle ahead of its reset release.
    core_rst_n_nxt = (state_nxt == S_RUN);
    mem_owner_nxt  = !((state_nxt == S_RUN) || ((state_nxt == S_HOLD) && (hold_nxt == 8'd0)));
    ld_ready_nxt   = (state_nxt == S_IDLE);
    busy_nxt       = (state_nxt == S_HOLD) || (state_nxt == S_RUN);
    done_nxt       = (state_nxt == S_DONE);
`ifdef RV_RUN_TIMEOUT_EN
    timeout_nxt    = (state_nxt == S_TIMEOUT);
`else
    timeout_nxt    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rv_pl_run_ctrl.sv
// Directed bench for rv_pl_run_ctrl: loads, hold/release timing, done filtering, ignored commands, async reset, timeout.
module tb_rv_pl_run_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        ld_sel = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        done_flag = 1'b0;
  logic        core_rst_n, mem_owner, imem_we;
  logic [3:0]  dmem_we;
  logic [11:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        busy, done, timeout;
  logic [31:0] cycle_count;

  int n_total = 0;
  int n_pass  = 0;

  rv_pl_run_ctrl #(.ADDR_W(12), .RST_HOLD(5), .DONE_STABLE(2), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .clear(clear), .done_flag(done_flag),
    .core_rst_n(core_rst_n), .mem_owner(mem_owner), .imem_we(imem_we), .dmem_we(dmem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_mem_owner"},  32'(mem_owner),  32'd1);
    check({tag, "_ld_ready"},   32'(ld_ready),   32'd1);
    check({tag, "_imem_we"},    32'(imem_we),    32'd0);
    check({tag, "_dmem_we"},    32'(dmem_we),    32'd0);
    check({tag, "_waddr"},      32'(mem_waddr),  32'd0);
    check({tag, "_wdata"},      mem_wdata,       32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_timeout"},    32'(timeout),    32'd0);
    check({tag, "_count"},      cycle_count,     32'd0);
  endtask

  initial begin
    step();
    step();
    check_reset_vals("rst");
    rst_n = 1'b0;
    step();

    // back-to-back IMEM loads
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 12'(i); ld_data = 32'hA5A5_0000 + 32'(i);
      step();
      check("imem_we", 32'(imem_we), 32'd1);
      check("imem_addr", 32'(mem_waddr), 32'(i));
      check("imem_data", mem_wdata, 32'hA5A5_0000 + 32'(i));
      check("imem_dmem_we", 32'(dmem_we), 32'd0);
    end
    ld_valid = 1'b0;
    step();
    check("imem_we_end", 32'(imem_we), 32'd0);

    // DMEM load then start
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 12'd0; ld_data = 32'h0000_0007;
    step();
    ld_valid = 1'b0;
    check("dmem_we", 32'(dmem_we), 32'hF);
    check("dmem_imem_we", 32'(imem_we), 32'd0);
    check("dmem_addr", 32'(mem_waddr), 32'd0);
    check("dmem_data", mem_wdata, 32'h7);
    step();
    check("dmem_we_end", 32'(dmem_we), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_ld_ready", 32'(ld_ready), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      check("hold_core_rst_n", 32'(core_rst_n), 32'd0);
      check("hold_mem_owner", 32'(mem_owner), (k == 5) ? 32'd0 : 32'd1);
      step();
    end
    check("run_core_rst_n", 32'(core_rst_n), 32'd1);
    check("run_mem_owner", 32'(mem_owner), 32'd0);
    check("run_count0", cycle_count, 32'd0);

    // RUN: glitch at run cycle 10, ignored start/load at 20, done_flag held from 40
    for (int m = 1; m <= 41; m++) begin
      done_flag = (m == 10) || (m >= 40);
      start     = (m == 20);
      ld_valid  = (m == 20) || (m == 21);
      ld_sel    = 1'b0;
      ld_addr   = 12'h3FF;
      if (m == 25) check("run_count25", cycle_count, 32'd24);
      step();
      check("run_done", 32'(done), (m >= 41) ? 32'd1 : 32'd0);
      if (m == 20 || m == 21) begin
        check("run_ld_ready", 32'(ld_ready), 32'd0);
        check("run_no_imem_we", 32'(imem_we), 32'd0);
        check("run_no_dmem_we", 32'(dmem_we), 32'd0);
        check("run_busy", 32'(busy), 32'd1);
        check("run_count_ign", cycle_count, 32'(m));
      end
    end
    start = 1'b0; ld_valid = 1'b0;
    check("done_count", cycle_count, 32'd41);
    check("done_core_rst_n", 32'(core_rst_n), 32'd0);
    check("done_mem_owner", 32'(mem_owner), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_ld_ready", 32'(ld_ready), 32'd0);
    step();
    step();
    check("done_frozen", cycle_count, 32'd41);
    check("done_held", 32'(done), 32'd1);
    done_flag = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_done", 32'(done), 32'd0);
    check("clr_ld_ready", 32'(ld_ready), 32'd1);
    check("clr_count_kept", cycle_count, 32'd41);

    // async reset mid-HOLD
    start = 1'b1;
    step();
    start = 1'b0;
    check("hold2_count_clr", cycle_count, 32'd0);
    step();
    #1 rst_n = 1'b1;
    #1 check_reset_vals("arst");
    #2 rst_n = 1'b0;
    step();
    ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 12'd9; ld_data = 32'hDEAD_BEEF;
    step();
    ld_valid = 1'b0;
    check("post_rst_imem_we", 32'(imem_we), 32'd1);
    check("post_rst_addr", 32'(mem_waddr), 32'd9);
    check("post_rst_data", mem_wdata, 32'hDEAD_BEEF);

    // run with done_flag low
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("to_run", 32'(core_rst_n), 32'd1);
`ifdef RV_RUN_TIMEOUT_EN
    repeat (49) step();
    check("to_pre", 32'(timeout), 32'd0);
    check("to_pre_count", cycle_count, 32'd49);
    step();
    check("to_fire", 32'(timeout), 32'd1);
    check("to_count", cycle_count, 32'd50);
    check("to_core_rst_n", 32'(core_rst_n), 32'd0);
    check("to_mem_owner", 32'(mem_owner), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("to_clr_timeout", 32'(timeout), 32'd0);
    check("to_clr_ld_ready", 32'(ld_ready), 32'd1);
`else
    repeat (60) step();
    check("noto_timeout", 32'(timeout), 32'd0);
    check("noto_busy", 32'(busy), 32'd1);
    check("noto_count", cycle_count, 32'd60);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("noto_clear_ign", 32'(busy), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rv_pl_run_ctrl.md
Name: rv_pl_run_ctrl

Overview:
Run controller that sits directly upstream of rv_pl_wrapper on the PL side. It owns the IMEM/DMEM BRAM write ports while the core is held in reset, accepts program/data words over a valid/ready load interface, and releases the core on a start command. It then counts execution cycles and latches completion when the core raises done_flag.

Parameters:
ADDR_W, 12, word-address width of the IMEM/DMEM write ports.
RST_HOLD, 5, cycles core_rst_n stays low after start before release; legal range 1..255.
DONE_STABLE, 2, consecutive cycles done_flag must be high before completion is declared; legal range 1..15.
TIMEOUT_CYC, 100000, run-cycle limit. Used only when RV_RUN_TIMEOUT_EN is defined.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
ld_valid  in  1  load word valid
ld_ready  out  1  load word accepted this cycle when ld_valid is also high
ld_sel  in  1  load target: 0 = IMEM, 1 = DMEM
ld_addr  in  ADDR_W  load word address
ld_data  in  32  load word data
start  in  1  single-cycle start request
clear  in  1  single-cycle return to IDLE from DONE or TIMEOUT
done_flag  in  1  completion flag from rv_pl_wrapper
core_rst_n  out  1  active-low reset driven to rv_pl_wrapper
mem_owner  out  1  1 = this block owns the BRAM write ports, so the external mux selects the loader
imem_we  out  1  IMEM write strobe
dmem_we  out  4  DMEM byte-write strobes; all-ones when writing
mem_waddr  out  ADDR_W  shared write address
mem_wdata  out  32  shared write data
busy  out  1  high in HOLD or RUN
done  out  1  high in DONE
timeout  out  1  high in TIMEOUT
cycle_count  out  32  core run cycles

Behaviour:
- Reset (rst_n high): state = IDLE.
  - core_rst_n = 0, mem_owner = 1, ld_ready = 1.
  - imem_we = 0, dmem_we = 0, mem_waddr = 0, mem_wdata = 0.
  - busy = done = timeout = 0, cycle_count = 0.
- All outputs are registered. Reset asserted mid-operation aborts immediately to the reset values above; no partial write survives.
- IDLE:
  - ld_ready = 1.
  - On ld_valid & ld_ready, the write is issued the next cycle for exactly 1 cycle: mem_waddr = ld_addr, mem_wdata = ld_data, and imem_we = 1 if ld_sel = 0, else dmem_we = 4'hF.
  - Back-to-back loads sustain 1 word per cycle.
  - start: go to HOLD and clear cycle_count. If start and ld_valid are high in the same cycle, the load is accepted and written first, and HOLD is entered after it.
- HOLD:
  - ld_ready = 0, core_rst_n = 0, busy = 1.
  - Hold counter runs RST_HOLD cycles.
  - mem_owner drops to 0 one cycle before core_rst_n rises, then the state moves to RUN.
- RUN:
  - core_rst_n = 1, mem_owner = 0, busy = 1, ld_ready = 0.
  - cycle_count += 1 every cycle and saturates at 0xFFFFFFFF; no wrap.
  - A done-stability counter increments while done_flag = 1 and resets to 0 when done_flag = 0.
  - When the counter reaches DONE_STABLE, go to DONE. cycle_count freezes at its value from that cycle.
- DONE:
  - done = 1, busy = 0, core_rst_n = 0 (core re-held), mem_owner = 1, ld_ready = 0.
  - clear: go to IDLE; done drops the next cycle and cycle_count is retained until the next start.
- start is ignored outside IDLE. clear is ignored outside DONE/TIMEOUT. Loads while ld_ready = 0 are stalled, not dropped.
- Latency:
  - load accept to BRAM write: 1 cycle.
  - start to core_rst_n rise: RST_HOLD+1 cycles.
  - first done_flag high to done: DONE_STABLE cycles.

Optional Feature:
RV_RUN_TIMEOUT_EN
- Defined: in RUN, if cycle_count reaches TIMEOUT_CYC without completion, go to TIMEOUT.
  - timeout = 1, core_rst_n = 0, mem_owner = 1.
  - clear returns to IDLE.
  - If done and timeout would fire in the same cycle, DONE wins.
- Undefined: the TIMEOUT state is not generated, timeout is tied to 0, and RUN waits indefinitely.

Test Plan:
1. After reset, load IMEM words 0..5 back-to-back (6 valid cycles) -> imem_we high for 6 consecutive cycles, mem_waddr 0..5, data matches, dmem_we = 0.
2. Load dmem addr 0 = 0x00000007 with ld_sel = 1, then start -> dmem_we = 4'hF for 1 cycle; core_rst_n low for exactly RST_HOLD = 5 cycles after the start cycle, then high; mem_owner falls one cycle before core_rst_n rises.
3. In RUN, drive a done_flag glitch of 1 cycle, then hold it high from run cycle 40 -> no completion on the glitch; done = 1 after 2 cycles of stable high; cycle_count = 41, frozen; core_rst_n = 0.
4. Pulse start during RUN and ld_valid during RUN -> both ignored; ld_ready = 0, no write strobes, count unaffected.
5. Assert rst_n mid-HOLD -> all outputs return to reset values asynchronously; IDLE accepts loads again after release.
6. With RV_RUN_TIMEOUT_EN and TIMEOUT_CYC = 50, done_flag held low -> timeout = 1 at cycle_count = 50, then clear -> IDLE and ld_ready = 1.
